// File: rtl/kyber_pkg.sv
// Shared constants for the Kyber polynomial compress stream.
// Lane/word geometry for the 3-bit v-polynomial packing.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int DV      = 3;
    localparam int LANES   = 8;
    localparam int COEFF_W = 12;
    localparam int BEAT_W  = LANES * COEFF_W;
    localparam int GRP_W   = LANES * DV;
    localparam int WORD_W  = 64;
    localparam int ACC_W   = 88;
    localparam int FILL_W  = 7;
    localparam int BEATS   = KYBER_N / LANES;
    localparam int WORDS   = (KYBER_N * DV) / WORD_W;
    localparam int BCNT_W  = $clog2(BEATS);
    localparam int WCNT_W  = $clog2(WORDS);

endpackage

// File: rtl/poly_compress_lane.sv
// Single-coefficient compress: c = ((x*8 + Q/2) / Q) mod 8.
// Exact division on the raw 12-bit value.
module poly_compress_lane
    import kyber_pkg::*;
(
    input  logic [COEFF_W-1:0] x,
    output logic [DV-1:0]      c
);

    logic [15:0] num;

    assign num = {1'b0, x, 3'b000} + 16'(KYBER_Q / 2);
    assign c   = DV'(num / 16'(KYBER_Q));

endmodule

// File: rtl/poly_compress_v_stream.sv
// Compress 8 coefficients per beat to 3 bits and pack them
// little-endian into a 64-bit word stream, 12 words per poly.
module poly_compress_v_stream
    import kyber_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BEAT_W-1:0] s_coeffs,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last
);

    logic [GRP_W-1:0]  grp;
    logic              p1_valid;
    logic [GRP_W-1:0]  p1_grp;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W-1:0]  acc_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic [FILL_W-1:0] wr_pos;
    logic [BCNT_W-1:0] bcnt;
    logic [WCNT_W-1:0] wcnt;
    logic              move;
    logic              p1_adv;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        poly_compress_lane u_lane (
            .x (s_coeffs[COEFF_W*k +: COEFF_W]),
            .c (grp[DV*k +: DV])
        );
    end

    // Word move / group advance decisions and next accumulator image
    always_comb begin
        move      = (fill >= FILL_W'(WORD_W)) && (!m_valid || m_ready);
        p1_adv    = p1_valid && ((fill < FILL_W'(WORD_W)) || move);
        s_ready   = !p1_valid || p1_adv;
        acc_base  = move ? (acc >> WORD_W) : acc;
        wr_pos    = move ? (fill - FILL_W'(WORD_W)) : fill;
        acc_next  = acc_base;
        fill_next = move ? (fill - FILL_W'(WORD_W)) : fill;
        if (p1_adv) begin
            acc_next  = acc_base | (ACC_W'(p1_grp) << wr_pos);
            fill_next = fill_next + FILL_W'(GRP_W);
        end
    end

    // P1: hold the compressed group until the accumulator takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid <= 1'b0;
            p1_grp   <= '0;
        end else if (s_ready) begin
            p1_valid <= s_valid;
            if (s_valid) p1_grp <= grp;
        end
    end

    // Accumulator, fill level and beat position within the poly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            fill <= '0;
            bcnt <= '0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;
            if (p1_adv) bcnt <= bcnt + 1'b1;
        end
    end

    // Output word register, held until downstream accepts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            wcnt    <= '0;
        end else if (move) begin
            m_valid <= 1'b1;
            m_data  <= acc[WORD_W-1:0];
            m_last  <= (wcnt == WCNT_W'(WORDS - 1));
            wcnt    <= (wcnt == WCNT_W'(WORDS - 1)) ? '0 : wcnt + 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_poly_compress_v_stream.sv
// Scoreboard bench for the v-polynomial compress stream.
// Reference model packs compressed bits through a bit queue.
module tb_poly_compress_v_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [95:0] s_coeffs = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [63:0] m_data;
    logic        m_last;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit rmode = 1'b0;
    int acc_cyc = 0;
    int words_seen = 0;
    int last_word_cyc = 0;

    bit          bitq[$];
    logic [64:0] expq[$];
    int          mwcnt = 0;

    bit          was_stall = 1'b0;
    logic [63:0] held_d = '0;
    logic        held_l = 1'b0;
    logic [64:0] e;

    poly_compress_v_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_coeffs (s_coeffs),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_ready <= rmode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int comp(input int x);
        return ((x * 8 + 1664) / 3329) % 8;
    endfunction

    task automatic model_reset();
        bitq.delete();
        expq.delete();
        mwcnt = 0;
    endtask

    task automatic model_beat(input logic [95:0] d);
        logic [63:0] w;
        int c;
        for (int k = 0; k < 8; k++) begin
            c = comp(int'(d[12*k +: 12]));
            for (int b = 0; b < 3; b++) bitq.push_back(bit'((c >> b) & 1));
        end
        while (bitq.size() >= 64) begin
            for (int i = 0; i < 64; i++) w[i] = bitq.pop_front();
            expq.push_back({(mwcnt == 11), w});
            mwcnt = (mwcnt + 1) % 12;
        end
    endtask

    task automatic send_beat(input logic [95:0] d);
        s_coeffs = d;
        s_valid = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (s_ready) begin
                model_beat(d);
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL s_ready_timeout actual=0 required=1");
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #2;
            if (expq.size() == 0) break;
        end
        chk(expq.size() == 0, "drain", 64'(expq.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rmode = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk(!m_valid && !m_last && m_data == 64'd0, "rst_async",
            {m_valid, m_last, m_data[61:0]}, 64'd0);
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk(s_ready == 1'b1, "rst_s_ready", 64'(s_ready), 64'd1);
        chk(!m_valid && m_data == 64'd0, "rst_m_valid",
            {m_valid, m_data[62:0]}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat(output logic [95:0] d);
        for (int k = 0; k < 8; k++) d[12*k +: 12] = 12'($urandom_range(0, 4095));
    endtask

    // Monitor: pop expected words on handshake, check stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (was_stall)
                chk(m_valid && m_data == held_d && m_last == held_l,
                    "stall_hold", m_data, held_d);
            if (!s_ready)
                chk(m_valid && !m_ready, "sready_drop",
                    64'({m_valid, m_ready}), 64'd2);
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word actual=%h required=none", m_data);
                end else begin
                    e = expq.pop_front();
                    chk(m_data == e[63:0], "word_data", m_data, e[63:0]);
                    chk(m_last == e[64], "word_last", 64'(m_last), 64'(e[64]));
                end
                words_seen <= words_seen + 1;
                last_word_cyc <= cyc;
            end
            was_stall <= m_valid && !m_ready;
            held_d <= m_data;
            held_l <= m_last;
        end else begin
            was_stall <= 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [95:0] d;
        int ramp[8];
        int bnd[8];
        int w0;
        int first_cyc;
        ramp = '{0, 416, 832, 1248, 1664, 2081, 2497, 2913};
        bnd  = '{0, 3328, 4095, 3329, 1664, 1665, 2496, 832};

        do_reset();

        // first-word latency with all lanes at Q/2
        for (int k = 0; k < 8; k++) d[12*k +: 12] = 12'd1664;
        for (int i = 0; i < 3; i++) send_beat(d);
        s_valid = 1'b0;
        @(negedge clk);
        chk(!m_valid, "lat_e0", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk(!m_valid, "lat_e1", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk(m_valid && !m_last && m_data == 64'h4924924924924924,
            "lat_e2", m_data, 64'h4924924924924924);
        wait_drain();
        do_reset();

        // ramp pattern, one full poly
        w0 = words_seen;
        for (int k = 0; k < 8; k++) d[12*k +: 12] = 12'(ramp[k]);
        for (int i = 0; i < 32; i++) send_beat(d);
        s_valid = 1'b0;
        wait_drain();
        chk(words_seen - w0 == 12, "ramp_words", 64'(words_seen - w0), 64'd12);

        // boundary values rotated across lanes
        w0 = words_seen;
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 8; k++) d[12*k +: 12] = 12'(bnd[(i + k) % 8]);
            send_beat(d);
        end
        s_valid = 1'b0;
        wait_drain();
        chk(words_seen - w0 == 12, "bnd_words", 64'(words_seen - w0), 64'd12);

        // random poly under random back-pressure
        rmode = 1'b1;
        w0 = words_seen;
        for (int i = 0; i < 32; i++) begin
            rand_beat(d);
            send_beat(d);
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        wait_drain();
        rmode = 1'b0;
        chk(words_seen - w0 == 12, "stall_words", 64'(words_seen - w0), 64'd12);
        repeat (2) @(posedge clk);
        #1;

        // two polys back to back, no bubbles
        w0 = words_seen;
        for (int i = 0; i < 64; i++) begin
            rand_beat(d);
            send_beat(d);
            if (i == 0) first_cyc = acc_cyc;
        end
        s_valid = 1'b0;
        wait_drain();
        chk(words_seen - w0 == 24, "b2b_words", 64'(words_seen - w0), 64'd24);
        chk(last_word_cyc - first_cyc == 66, "b2b_timing",
            64'(last_word_cyc - first_cyc), 64'd66);

        // reset mid-poly after 13 beats
        for (int i = 0; i < 13; i++) begin
            rand_beat(d);
            send_beat(d);
        end
        do_reset();
        w0 = words_seen;
        for (int i = 0; i < 32; i++) begin
            rand_beat(d);
            send_beat(d);
        end
        s_valid = 1'b0;
        wait_drain();
        chk(words_seen - w0 == 12, "post_rst_words", 64'(words_seen - w0), 64'd12);

        // 64 random polys, back-pressure on alternate polys
        w0 = words_seen;
        for (int p = 0; p < 64; p++) begin
            rmode = p[0];
            for (int i = 0; i < 32; i++) begin
                rand_beat(d);
                send_beat(d);
            end
        end
        s_valid = 1'b0;
        wait_drain();
        rmode = 1'b0;
        chk(words_seen - w0 == 768, "rand_words", 64'(words_seen - w0), 64'd768);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
